// File: rtl/clks_alot_p.sv
// Shared types and widths for the clks_alot clock generator.
package clks_alot_p;

  localparam int RATE_COUNTER_WIDTH   = 8;
  localparam int PAUSE_DURATION_WIDTH = 8;

  typedef logic [RATE_COUNTER_WIDTH-1:0]   rate_t;
  typedef logic [RATE_COUNTER_WIDTH:0]     period_t;
  typedef logic [PAUSE_DURATION_WIDTH-1:0] pause_dur_t;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    PAUSED
  } gen_state_e;

  typedef struct packed {
    rate_t high_rate;
    rate_t low_rate;
    logic  even_50_50_en;
    logic  diff_en;
  } gen_conf_s;

  typedef struct packed {
    logic primary;
    logic secondary;
  } recovery_drivers_s;

  typedef struct packed {
    logic       pause_active;
    pause_dur_t pause_duration;
    logic       locked;
  } status_s;

  typedef struct packed {
    logic rising_edge;
    logic falling_edge;
    logic steady_high;
    logic steady_low;
  } generated_events_s;

  typedef struct packed {
    logic              clk;
    status_s           status;
    generated_events_s events;
  } clock_state_s;

  // A zero rate behaves as a one-cycle phase.
  function automatic rate_t eff_rate(input rate_t r);
    return (r == '0) ? rate_t'(1) : r;
  endfunction

  function automatic rate_t low_phase_rate(input gen_conf_s c);
    return c.even_50_50_en ? c.high_rate : c.low_rate;
  endfunction

endpackage

// File: rtl/clks_alot_half_timer.sv
// Phase-length down-counter: loads R-1 (R=0 acts as 1) and flags expiry at zero.
module clks_alot_half_timer
  import clks_alot_p::*;
(
  input  logic  sys_clk,
  input  logic  sys_rst_n,
  input  logic  load,
  input  rate_t rate,
  output logic  expired
);

  rate_t cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (rate == '0) ? '0 : rate - rate_t'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - rate_t'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/clks_alot_gen.sv
// Programmable clock generator: high/low phase FSM with shadowed config, pause and lock status.
module clks_alot_gen
  import clks_alot_p::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable_i,
  input  logic              conf_update_i,
  input  rate_t             high_rate_i,
  input  rate_t             low_rate_i,
  input  logic              even_50_50_en_i,
  input  logic              diff_en_i,
  input  logic              pause_req_i,
  output recovery_drivers_s drivers_o,
  output clock_state_s      clock_state_o
);

  gen_state_e        state, next_state;
  gen_conf_s         shadow, pending, in_conf, pend_eff, active_conf;
  logic              pending_valid;
  logic              primary_q, secondary_q;
  generated_events_s events_q, events_next;
  logic              pause_active_q, locked_q;
  pause_dur_t        pause_duration_q;
  period_t           pause_cnt, pause_cnt_next, pause_period;
  logic              timer_load, expired;
  rate_t             timer_rate;
  logic              running, apply_now, boundary, boundary_apply, conf_apply;

  clks_alot_half_timer u_half_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (timer_load),
    .rate      (timer_rate),
    .expired   (expired)
  );

  assign in_conf = '{high_rate:     high_rate_i,
                     low_rate:      low_rate_i,
                     even_50_50_en: even_50_50_en_i,
                     diff_en:       diff_en_i};

  // Strobes while running are parked until the period boundary; a strobe on
  // the boundary cycle itself is the newest config and applies directly.
  assign running        = (state == HIGH) || (state == LOW);
  assign apply_now      = conf_update_i && !running;
  assign boundary       = (state == LOW) && expired;
  assign pend_eff       = conf_update_i ? in_conf : pending;
  assign boundary_apply = boundary && (pending_valid || conf_update_i);
  assign conf_apply     = apply_now || boundary_apply;
  assign active_conf    = apply_now ? in_conf : (boundary_apply ? pend_eff : shadow);

  assign pause_period   = period_t'(eff_rate(shadow.high_rate))
                        + period_t'(eff_rate(low_phase_rate(shadow)));
  assign pause_cnt_next = pause_cnt + period_t'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_rate = active_conf.high_rate;
    case (state)
      IDLE: begin
        if (enable_i) begin
          next_state = HIGH;
          timer_load = 1'b1;
        end
      end
      HIGH: begin
        if (expired) begin
          next_state = LOW;
          timer_load = 1'b1;
          timer_rate = low_phase_rate(active_conf);
        end
      end
      LOW: begin
        if (expired) begin
          if (!enable_i) begin
            next_state = IDLE;
          end else if (pause_req_i) begin
            next_state = PAUSED;
          end else begin
            next_state = HIGH;
            timer_load = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (!enable_i) begin
          next_state = IDLE;
        end else if (!pause_req_i) begin
          next_state = HIGH;
          timer_load = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    events_next = '0;
    case (next_state)
      HIGH: begin
        if (state != HIGH) events_next.rising_edge = 1'b1;
        else               events_next.steady_high = 1'b1;
      end
      LOW: begin
        if (state != LOW) events_next.falling_edge = 1'b1;
        else              events_next.steady_low   = 1'b1;
      end
      default: events_next.steady_low = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= IDLE;
      primary_q        <= 1'b0;
      secondary_q      <= 1'b0;
      shadow           <= '0;
      pending          <= '0;
      pending_valid    <= 1'b0;
      events_q         <= '{steady_low: 1'b1, default: 1'b0};
      pause_active_q   <= 1'b0;
      pause_duration_q <= '0;
      pause_cnt        <= '0;
      locked_q         <= 1'b0;
    end else begin
      state       <= next_state;
      primary_q   <= (next_state == HIGH);
      secondary_q <= active_conf.diff_en && (next_state != HIGH);
      shadow      <= active_conf;
      events_q    <= events_next;

      if (conf_update_i && running && !boundary) begin
        pending       <= in_conf;
        pending_valid <= 1'b1;
      end else if (boundary) begin
        pending_valid <= 1'b0;
      end

      pause_active_q <= (next_state == PAUSED);
      if ((next_state == PAUSED) && (state != PAUSED)) begin
        pause_cnt        <= '0;
        pause_duration_q <= '0;
      end else if (state == PAUSED) begin
        if (pause_cnt_next >= pause_period) begin
          pause_cnt <= '0;
          if (pause_duration_q != '1) pause_duration_q <= pause_duration_q + pause_dur_t'(1);
        end else begin
          pause_cnt <= pause_cnt_next;
        end
      end

      // Lock needs one full period on a stable config; PAUSED simply holds it.
      if ((next_state == IDLE) || conf_apply) locked_q <= 1'b0;
      else if (boundary)                      locked_q <= 1'b1;
    end
  end

  // While reset is held the shadow is cleared, so the secondary pin follows diff_en_i directly.
  assign drivers_o = '{primary:   primary_q,
                       secondary: sys_rst_n ? secondary_q : diff_en_i};

  assign clock_state_o = '{clk:    primary_q,
                           status: '{pause_active:   pause_active_q,
                                     pause_duration: pause_duration_q,
                                     locked:         locked_q},
                           events: events_q};

endmodule
